seq_datapath: RTL and testbench

// - Parametrised single-bus CPU datapath with a built-in T-step sequencer: fetch, decode, execute with no external control strobes.
// - Replaces per-signal Rin/Rout control with an internal FSM and a ready-handshaked memory port (wait states supported).
// - Sits between the top-level CPU wrapper and the RAM; debug read port exposes the register file to the bench.

---
 rtl/datapath_pkg.sv | 43 ++++
 rtl/dp_alu.sv | 48 ++++
 rtl/seq_datapath.sv | 196 +++++++++++++++++++
 tb/tb_seq_datapath.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
// Shared definitions for the sequenced single-bus datapath.
// Holds the opcode map, the T-step state encoding, the IR field positions,
// and a helper that says whether an opcode does anything.
// No ports: this is a package.
package datapath_pkg;

    localparam logic [4:0] OP_LD   = 5'd0;
    localparam logic [4:0] OP_LDI  = 5'd1;
    localparam logic [4:0] OP_ST   = 5'd2;
    localparam logic [4:0] OP_ADD  = 5'd3;
    localparam logic [4:0] OP_SUB  = 5'd4;
    localparam logic [4:0] OP_AND  = 5'd5;
    localparam logic [4:0] OP_OR   = 5'd6;
    localparam logic [4:0] OP_SHR  = 5'd7;
    localparam logic [4:0] OP_SHL  = 5'd8;
    localparam logic [4:0] OP_MUL  = 5'd15;
    localparam logic [4:0] OP_MFHI = 5'd23;
    localparam logic [4:0] OP_MFLO = 5'd24;
    localparam logic [4:0] OP_HALT = 5'd31;

    // IR field positions (instruction word is 32 bits wide)
    localparam int OP_LSB = 27;
    localparam int RA_LSB = 23;
    localparam int RB_LSB = 19;
    localparam int RC_LSB = 15;
    localparam int C_W    = 19;

    typedef enum logic [3:0] {
        S_IDLE,
        S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7,
        S_HALT
    } state_t;

    // Opcodes outside this set execute as a nop after decode.
    function automatic logic op_known(input logic [4:0] op);
        case (op)
            OP_LD, OP_LDI, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_SHR, OP_SHL, OP_MUL, OP_MFHI, OP_MFLO: return 1'b1;
            default:                                  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dp_alu.sv
// Combinational ALU for the sequenced datapath.
// Ports:
//   op_i   opcode selecting the operation (ld/ldi/st arrive here as add)
//   a_i    operand A (Y register)
//   b_i    operand B (R[rc] or sign-extended constant)
//   res_o  2*DATA_W result; only mul uses the upper half
module dp_alu
    import datapath_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [4:0]          op_i,
    input  logic [DATA_W-1:0]   a_i,
    input  logic [DATA_W-1:0]   b_i,
    output logic [2*DATA_W-1:0] res_o
);

    localparam int SH_W = $clog2(DATA_W);

    logic signed [2*DATA_W-1:0] a_ext;
    logic signed [2*DATA_W-1:0] b_ext;
    logic signed [2*DATA_W-1:0] prod;
    logic [SH_W-1:0]            sh;
    logic [DATA_W-1:0]          lo;

    // Sign-extend to full product width so the truncated product is the
    // exact signed 2*DATA_W result.
    assign a_ext = {{DATA_W{a_i[DATA_W-1]}}, a_i};
    assign b_ext = {{DATA_W{b_i[DATA_W-1]}}, b_i};
    assign prod  = a_ext * b_ext;
    assign sh    = b_i[SH_W-1:0];

    always_comb begin
        lo = '0;
        case (op_i)
            OP_ADD:  lo = a_i + b_i;
            OP_SUB:  lo = a_i - b_i;
            OP_AND:  lo = a_i & b_i;
            OP_OR:   lo = a_i | b_i;
            OP_SHR:  lo = a_i >> sh;
            OP_SHL:  lo = a_i << sh;
            default: lo = '0;
        endcase
    end

    assign res_o = (op_i == OP_MUL) ? prod : {{DATA_W{1'b0}}, lo};

endmodule

// File: rtl/seq_datapath.sv
// Single-bus CPU datapath with an internal T-step sequencer.
// Ports:
//   clock, clear      rising-edge clock, asynchronous active-low reset
//   start             begins execution at PC when idle or halted
//   busy, halted      sequencer status
//   mem_addr/rd/wr    memory request (held until mem_ready), address = MAR
//   mem_wdata         write data = MDR
//   mem_rdata/ready   read data and completion strobe
//   pc_out, ir_out    PC and IR registers
//   dbg_sel/dbg_data  combinational register-file read port
module seq_datapath
    import datapath_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 9,
    parameter logic [DATA_W-1:0] PC_RESET = '0
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              start,
    output logic              busy,
    output logic              halted,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] pc_out,
    output logic [DATA_W-1:0] ir_out,
    input  logic [3:0]        dbg_sel,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int RIDX_W = $clog2(NUM_REGS);
    localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

    state_t state_q, state_d;
    logic [DATA_W-1:0]   pc_q, pc_d, mar_q, mar_d, mdr_q, mdr_d, ir_q, ir_d;
    logic [DATA_W-1:0]   y_q, y_d, hi_q, hi_d, lo_q, lo_d;
    logic [2*DATA_W-1:0] z_q, z_d;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];

    logic                rf_we;
    logic [DATA_W-1:0]   rf_wdata;

    logic [4:0]          op;
    logic [RIDX_W-1:0]   ra, rb, rc;
    logic [DATA_W-1:0]   c_ext, alu_b;
    logic [4:0]          alu_op;
    logic [2*DATA_W-1:0] alu_res;
    logic                is_mem_or_imm;

    assign op    = ir_q[OP_LSB +: 5];
    assign ra    = ir_q[RA_LSB +: RIDX_W];
    assign rb    = ir_q[RB_LSB +: RIDX_W];
    assign rc    = ir_q[RC_LSB +: RIDX_W];
    assign c_ext = {{(DATA_W-C_W){ir_q[C_W-1]}}, ir_q[C_W-1:0]};

    // ld/ldi/st compute base + C through the adder.
    assign is_mem_or_imm = (op == OP_LD) || (op == OP_LDI) || (op == OP_ST);
    assign alu_op        = is_mem_or_imm ? OP_ADD : op;
    assign alu_b         = is_mem_or_imm ? c_ext : regs_q[rc];

    dp_alu #(.DATA_W(DATA_W)) u_alu (
        .op_i  (alu_op),
        .a_i   (y_q),
        .b_i   (alu_b),
        .res_o (alu_res)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        mar_d    = mar_q;
        mdr_d    = mdr_q;
        ir_d     = ir_q;
        y_d      = y_q;
        z_d      = z_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        rf_we    = 1'b0;
        rf_wdata = '0;
        case (state_q)
            S_IDLE, S_HALT: if (start) state_d = S_T0;
            S_T0: begin
                mar_d   = pc_q;
                z_d     = {{DATA_W{1'b0}}, pc_q + ONE};
                state_d = S_T1;
            end
            S_T1: begin
                pc_d = z_q[DATA_W-1:0];
                if (mem_ready) begin
                    mdr_d   = mem_rdata;
                    state_d = S_T2;
                end
            end
            S_T2: begin
                ir_d    = mdr_q;
                state_d = S_T3;
            end
            S_T3: begin
                // Base-address rule: R0 as a base reads as zero only here.
                y_d = (is_mem_or_imm && rb == '0) ? '0 : regs_q[rb];
                if (op == OP_HALT)     state_d = S_HALT;
                else if (!op_known(op)) state_d = S_T0;
                else                    state_d = S_T4;
            end
            S_T4: begin
                if (op == OP_MFHI || op == OP_MFLO) begin
                    rf_we    = 1'b1;
                    rf_wdata = (op == OP_MFHI) ? hi_q : lo_q;
                    state_d  = S_T0;
                end else begin
                    z_d     = alu_res;
                    state_d = S_T5;
                end
            end
            S_T5: begin
                if (op == OP_LD || op == OP_ST) begin
                    mar_d   = z_q[DATA_W-1:0];
                    state_d = S_T6;
                end else if (op == OP_MUL) begin
                    hi_d    = z_q[2*DATA_W-1:DATA_W];
                    lo_d    = z_q[DATA_W-1:0];
                    state_d = S_T0;
                end else begin
                    rf_we    = 1'b1;
                    rf_wdata = z_q[DATA_W-1:0];
                    state_d  = S_T0;
                end
            end
            S_T6: begin
                if (op == OP_LD) begin
                    if (mem_ready) begin
                        mdr_d   = mem_rdata;
                        state_d = S_T7;
                    end
                end else begin
                    mdr_d   = regs_q[ra];
                    state_d = S_T7;
                end
            end
            S_T7: begin
                if (op == OP_LD) begin
                    rf_we    = 1'b1;
                    rf_wdata = mdr_q;
                    state_d  = S_T0;
                end else if (mem_ready) begin
                    state_d = S_T0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= S_IDLE;
            pc_q    <= PC_RESET;
            mar_q   <= '0;
            mdr_q   <= '0;
            ir_q    <= '0;
            y_q     <= '0;
            z_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            mar_q   <= mar_d;
            mdr_q   <= mdr_d;
            ir_q    <= ir_d;
            y_q     <= y_d;
            z_q     <= z_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            if (rf_we) regs_q[ra] <= rf_wdata;
        end
    end

    // Requests decode straight from the state register, so they drop the
    // instant clear is asserted and never overlap.
    assign mem_rd    = (state_q == S_T1) || (state_q == S_T6 && op == OP_LD);
    assign mem_wr    = (state_q == S_T7) && (op == OP_ST);
    assign mem_addr  = mar_q[ADDR_W-1:0];
    assign mem_wdata = mdr_q;
    assign busy      = (state_q != S_IDLE) && (state_q != S_HALT);
    assign halted    = (state_q == S_HALT);
    assign pc_out    = pc_q;
    assign ir_out    = ir_q;
    assign dbg_data  = regs_q[dbg_sel[RIDX_W-1:0]];

endmodule

// File: tb/tb_seq_datapath.sv
module tb_seq_datapath;

    logic        clock = 1'b0;
    logic        clear;
    logic        start;
    logic        busy, halted, mem_rd, mem_wr, mem_ready;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata, pc_out, ir_out, dbg_data;
    logic [3:0]  dbg_sel;

    logic [31:0] mem [512];
    logic        rd_rdy, wr_rdy;
    int          checks = 0, errors = 0, cyc = 0;
    int          wr_cnt = 0, overlap = 0;
    logic [8:0]  wr_addr;
    logic [31:0] wr_data;

    assign mem_rdata = mem[mem_addr];
    assign mem_ready = mem_wr ? wr_rdy : rd_rdy;

    always #5 clock = ~clock;

    seq_datapath dut (
        .clock(clock), .clear(clear), .start(start), .busy(busy), .halted(halted),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .pc_out(pc_out), .ir_out(ir_out),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    typedef struct {
        string       name;
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[10];

    function automatic logic [31:0] enc(input logic [4:0] op, input logic [3:0] ra,
                                        input logic [3:0] rb, input logic [18:0] c);
        return {op, ra, rb, c};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] op, input logic [3:0] ra,
                                          input logic [3:0] rb, input logic [3:0] rc);
        return {op, ra, rb, rc, 15'h0};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One clock: commit any write the memory accepts on this edge, then
    // wait for the next falling edge where outputs are sampled.
    task automatic step();
        if (mem_rd && mem_wr) overlap++;
        if (mem_wr && mem_ready) begin
            mem[mem_addr] = mem_wdata;
            wr_cnt++;
            wr_addr = mem_addr;
            wr_data = mem_wdata;
        end
        @(negedge clock);
        cyc++;
    endtask

    task automatic do_reset();
        clear = 1'b0;
        step();
        step();
        clear = 1'b1;
        step();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic run_halt(input int max);
        int n = 0;
        while (!halted && n < max) begin
            step();
            n++;
        end
        chk("halt_reached", {31'h0, halted}, 32'h1);
    endtask

    task automatic read_reg(input int r, output logic [31:0] v);
        dbg_sel = r[3:0];
        #1;
        v = dbg_data;
    endtask

    task automatic mem_wipe();
        for (int i = 0; i < 512; i++) mem[i] = 32'h0;
    endtask

    task automatic load_prog2();
        mem_wipe();
        mem[0] = enc(5'd1, 4'd2, 4'd0, 19'h65);
        mem[1] = enc(5'd1, 4'd3, 4'd0, 19'h1E);
        mem[2] = enc_r(5'd3, 4'd4, 4'd2, 4'd3);
        mem[3] = enc(5'd31, 4'd0, 4'd0, 19'h0);
        mem[4] = enc(5'd1, 4'd5, 4'd0, 19'h7);
        mem[5] = enc(5'd31, 4'd0, 4'd0, 19'h0);
    endtask

    initial begin
        logic [31:0] v;
        int          t0, hcnt, wc0, n;

        vecs[0] = '{"add_ovf",   5'd3, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000};
        vecs[1] = '{"add_wrap",  5'd3, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
        vecs[2] = '{"sub_neg",   5'd4, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE};
        vecs[3] = '{"and",       5'd5, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234};
        vecs[4] = '{"or",        5'd6, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F};
        vecs[5] = '{"shr_log",   5'd7, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000};
        vecs[6] = '{"shr_mod",   5'd7, 32'h8000_0000, 32'h0000_0021, 32'h4000_0000};
        vecs[7] = '{"shl_31",    5'd8, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000};
        vecs[8] = '{"shl_mod",   5'd8, 32'h0000_0003, 32'h0000_0020, 32'h0000_0003};
        vecs[9] = '{"nop_op9",   5'd9, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000};

        clear = 1'b0; start = 1'b0; dbg_sel = 4'd0; rd_rdy = 1'b1; wr_rdy = 1'b1;
        mem_wipe();
        #1;
        chk("por_busy", {31'h0, busy}, 32'h0);
        chk("por_pc", pc_out, 32'h0);
        do_reset();

        // Clear in the middle of a run, after R2 has been written
        load_prog2();
        pulse_start();
        for (int i = 0; i < 8; i++) step();
        chk("pre_clear_busy", {31'h0, busy}, 32'h1);
        #1;
        clear = 1'b0;
        #1;
        chk("clr_pc", pc_out, 32'h0);
        chk("clr_busy", {31'h0, busy}, 32'h0);
        chk("clr_mem_rd", {31'h0, mem_rd}, 32'h0);
        for (int r = 0; r < 16; r++) begin
            read_reg(r, v);
            chk($sformatf("clr_R%0d", r), v, 32'h0);
        end
        step();
        clear = 1'b1;
        step();

        // Baseline program: ldi/ldi/add/halt, then resume from HALT
        load_prog2();
        do_reset();
        t0 = cyc;
        pulse_start();
        run_halt(100);
        chk("prog_cycles", cyc - t0, 32'd23);
        read_reg(4, v);
        chk("prog_R4", v, 32'h83);
        chk("prog_halted", {31'h0, halted}, 32'h1);
        chk("prog_pc", pc_out, 32'h4);
        pulse_start();
        run_halt(100);
        read_reg(5, v);
        chk("resume_R5", v, 32'h7);
        chk("resume_pc", pc_out, 32'h6);

        // Same program with three wait states on the first fetch
        load_prog2();
        do_reset();
        rd_rdy = 1'b0;
        t0 = cyc;
        pulse_start();
        step();
        hcnt = 0;
        for (int k = 0; k < 8; k++) begin
            if (!mem_rd) break;
            if (mem_addr == 9'h0) hcnt++;
            if (k == 3) rd_rdy = 1'b1;
            step();
        end
        rd_rdy = 1'b1;
        chk("stall_hold_cycles", hcnt, 32'd4);
        run_halt(100);
        chk("stall_cycles", cyc - t0, 32'd26);
        read_reg(4, v);
        chk("stall_R4", v, 32'h83);

        // Table of ALU operations: ld R1/R2 from data words, op R3, halt
        foreach (vecs[i]) begin
            mem_wipe();
            mem[0] = enc(5'd0, 4'd1, 4'd0, 19'h100);
            mem[1] = enc(5'd0, 4'd2, 4'd0, 19'h101);
            mem[2] = enc_r(vecs[i].op, 4'd3, 4'd1, 4'd2);
            mem[3] = enc(5'd31, 4'd0, 4'd0, 19'h0);
            mem[9'h100] = vecs[i].a;
            mem[9'h101] = vecs[i].b;
            do_reset();
            pulse_start();
            run_halt(100);
            read_reg(3, v);
            chk(vecs[i].name, v, vecs[i].exp);
        end

        // Signed multiply into HI/LO, read back with mfhi/mflo
        mem_wipe();
        mem[0] = enc(5'd1, 4'd5, 4'd0, 19'h7FFFF);
        mem[1] = enc(5'd1, 4'd6, 4'd0, 19'h2);
        mem[2] = enc_r(5'd15, 4'd0, 4'd5, 4'd6);
        mem[3] = enc(5'd23, 4'd7, 4'd0, 19'h0);
        mem[4] = enc(5'd24, 4'd8, 4'd0, 19'h0);
        mem[5] = enc(5'd31, 4'd0, 4'd0, 19'h0);
        do_reset();
        pulse_start();
        run_halt(200);
        read_reg(5, v);
        chk("mul_R5", v, 32'hFFFF_FFFF);
        read_reg(7, v);
        chk("mfhi_R7", v, 32'hFFFF_FFFF);
        read_reg(8, v);
        chk("mflo_R8", v, 32'hFFFF_FFFE);
        read_reg(0, v);
        chk("mul_R0_untouched", v, 32'h0);

        // Store then load through base R0, then R0 as a normal register
        mem_wipe();
        mem[0] = enc(5'd1, 4'd1, 4'd0, 19'hA5);
        mem[1] = enc(5'd2, 4'd1, 4'd0, 19'h40);
        mem[2] = enc(5'd0, 4'd9, 4'd0, 19'h40);
        mem[3] = enc(5'd1, 4'd0, 4'd0, 19'h5);
        mem[4] = enc(5'd0, 4'd10, 4'd0, 19'h40);
        mem[5] = enc_r(5'd3, 4'd11, 4'd0, 4'd0);
        mem[6] = enc(5'd31, 4'd0, 4'd0, 19'h0);
        do_reset();
        wc0 = wr_cnt;
        overlap = 0;
        t0 = cyc;
        pulse_start();
        run_halt(200);
        chk("stld_cycles", cyc - t0, 32'd47);
        chk("st_wr_count", wr_cnt - wc0, 32'd1);
        chk("st_wr_addr", {23'h0, wr_addr}, 32'h40);
        chk("st_wr_data", wr_data, 32'hA5);
        read_reg(9, v);
        chk("ld_R9", v, 32'hA5);
        read_reg(10, v);
        chk("ld_base_R0_is_zero", v, 32'hA5);
        read_reg(11, v);
        chk("add_R0_readable", v, 32'hA);
        chk("rd_wr_overlap", overlap, 32'd0);

        // Clear while a store is stalled in its write step
        mem_wipe();
        mem[0] = enc(5'd1, 4'd1, 4'd0, 19'h77);
        mem[1] = enc(5'd2, 4'd1, 4'd0, 19'h40);
        mem[2] = enc(5'd31, 4'd0, 4'd0, 19'h0);
        mem[9'h40] = 32'h1234_5678;
        do_reset();
        wr_rdy = 1'b0;
        wc0 = wr_cnt;
        pulse_start();
        n = 0;
        while (!mem_wr && n < 60) begin
            step();
            n++;
        end
        chk("st_wr_reached", {31'h0, mem_wr}, 32'h1);
        step();
        step();
        chk("st_hold_wr", {31'h0, mem_wr}, 32'h1);
        chk("st_hold_addr", {23'h0, mem_addr}, 32'h40);
        chk("st_hold_data", mem_wdata, 32'h77);
        #1;
        clear = 1'b0;
        #1;
        chk("clr_st_mem_wr", {31'h0, mem_wr}, 32'h0);
        chk("clr_st_busy", {30'h0, busy, halted}, 32'h0);
        step();
        clear = 1'b1;
        wr_rdy = 1'b1;
        step();
        step();
        chk("clr_st_mem_kept", mem[9'h40], 32'h1234_5678);
        chk("clr_st_no_write", wr_cnt - wc0, 32'd0);
        chk("clr_st_idle", {30'h0, busy, halted}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
